hbridge_driver: RTL and testbench

HBRIDGE_DRIVER -- requirements
Module: hbridge_driver

---
 rtl/hbridge_driver.sv | 123 ++++++++++++
 tb/tb_hbridge_driver.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/hbridge_driver.sv
// H-bridge gate driver with dead-time insertion and latched fault shutdown.
//
// Builds the wanted switch pattern {hiA,loA,hiB,loB} from the enable, note
// polarity and PWM carrier, then applies it so that no leg ever shoots through:
// a switch turns on only after its complement has been off for DEAD_CYCLES
// clock cycles. Turn-offs are applied on the next edge.
//
// Ports:
//   clk        - system clock (40 MHz)
//   reset      - asynchronous active-high reset
//   en         - bridge enable; 0 turns every switch off
//   sign       - note polarity (0 positive, 1 negative)
//   pwmIn      - PWM carrier
//   faultIn    - overcurrent flag, synchronous to clk
//   clearFault - single-cycle request to clear a latched fault
//   hiA/loA    - leg A high/low-side gate drive (registered)
//   hiB/loB    - leg B high/low-side gate drive (registered)
//   faulted    - latched fault status
//   deadActive - high while a dead-time interval is running
module hbridge_driver #(
  parameter int unsigned DEAD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sign,
  input  logic pwmIn,
  input  logic faultIn,
  input  logic clearFault,
  output logic hiA,
  output logic loA,
  output logic hiB,
  output logic loB,
  output logic faulted,
  output logic deadActive
);

  typedef enum logic [0:0] {StDrive, StDead} state_e;

  localparam logic [7:0] CntLoad = 8'(DEAD_CYCLES - 1);

  state_e     st_q, st_d;
  logic [3:0] a_q, a_d;      // applied vector, drives the gates
  logic [3:0] l_q, l_d;      // target latched when the dead interval started
  logic [7:0] cnt_q, cnt_d;
  logic       faulted_q, faulted_d;
  logic [3:0] tgt;

  // Wanted switch pattern, {hiA,loA,hiB,loB}.
  always_comb begin
    tgt = 4'b0000;
    if (en && !faulted_q) begin
      if (!pwmIn)    tgt = 4'b0101;
      else if (sign) tgt = 4'b0110;
      else           tgt = 4'b1001;
    end
  end

  always_comb begin
    st_d      = st_q;
    a_d       = a_q;
    l_d       = l_q;
    cnt_d     = cnt_q;
    faulted_d = faulted_q;
    if (faultIn) begin
      // Fault wins over everything, including a simultaneous clear.
      faulted_d = 1'b1;
      a_d       = 4'b0000;
      st_d      = StDrive;
    end else begin
      if (clearFault) faulted_d = 1'b0;
      unique case (st_q)
        StDrive: begin
          if (tgt != a_q) begin
            if ((tgt & ~a_q) == 4'b0000) begin
              a_d = tgt;                 // pure turn-off: no dead time needed
            end else begin
              a_d   = a_q & tgt;         // drop switches that must go off now
              l_d   = tgt;
              cnt_d = CntLoad;
              st_d  = StDead;
            end
          end
        end
        StDead: begin
          if (tgt != l_q) begin
            // Target moved while waiting: restart the full dead interval.
            a_d   = a_q & tgt;
            l_d   = tgt;
            cnt_d = CntLoad;
          end else if (cnt_q == 8'd0) begin
            a_d  = l_q;
            st_d = StDrive;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: st_d = StDrive;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q      <= StDrive;
      a_q       <= 4'b0000;
      l_q       <= 4'b0000;
      cnt_q     <= 8'd0;
      faulted_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      a_q       <= a_d;
      l_q       <= l_d;
      cnt_q     <= cnt_d;
      faulted_q <= faulted_d;
    end
  end

  assign {hiA, loA, hiB, loB} = a_q;
  assign faulted    = faulted_q;
  assign deadActive = (st_q == StDead);

endmodule

// File: tb/tb_hbridge_driver.sv
// Directed bench for hbridge_driver with DEAD_CYCLES = 4. A negedge monitor
// checks shoot-through and complement-off time on every cycle.
module tb_hbridge_driver;

  localparam int unsigned Dead = 4;

  logic clk = 1'b0;
  logic reset, en, sign, pwmIn, faultIn, clearFault;
  logic hiA, loA, hiB, loB, faulted, deadActive;

  int n_checks = 0;
  int n_errors = 0;

  hbridge_driver #(.DEAD_CYCLES(Dead)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sign       (sign),
    .pwmIn      (pwmIn),
    .faultIn    (faultIn),
    .clearFault (clearFault),
    .hiA        (hiA),
    .loA        (loA),
    .hiB        (hiB),
    .loB        (loB),
    .faulted    (faulted),
    .deadActive (deadActive)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check gate vector and deadActive after one edge.
  task automatic step(input string tag, input logic [3:0] exp_out, input logic exp_dead);
    tick();
    check({tag, "_out"}, {28'd0, hiA, loA, hiB, loB}, {28'd0, exp_out});
    check({tag, "_dead"}, {31'd0, deadActive}, {31'd0, exp_dead});
  endtask

  // Full dead interval: Dead edges showing mid_out with deadActive, then final_out.
  task automatic dead_then(input string tag, input logic [3:0] mid_out,
                           input logic [3:0] final_out);
    for (int i = 0; i < int'(Dead); i++) step(tag, mid_out, 1'b1);
    step({tag, "_on"}, final_out, 1'b0);
  endtask

  // Per-cycle safety monitor.
  logic [3:0] prev_v = 4'b0000;
  int         zc[4] = '{0, 0, 0, 0};
  always @(negedge clk) begin
    logic [3:0] cur;
    cur = {hiA, loA, hiB, loB};
    check("shoot_through", {30'd0, hiA & loA, hiB & loB}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (cur[i] && !prev_v[i]) check("dead_gap", {31'd0, zc[i ^ 1] >= int'(Dead)}, 32'd1);
    end
    for (int i = 0; i < 4; i++) zc[i] = cur[i] ? 0 : (zc[i] < 1000 ? zc[i] + 1 : zc[i]);
    prev_v = cur;
  end

  initial begin
    reset = 1'b1; en = 1'b0; sign = 1'b0; pwmIn = 1'b0; faultIn = 1'b0; clearFault = 1'b0;
    #1;
    check("rst_out", {28'd0, hiA, loA, hiB, loB}, 32'd0);
    check("rst_faulted", {31'd0, faulted}, 32'd0);
    check("rst_dead", {31'd0, deadActive}, 32'd0);
    tick(); tick();

    // V1: release reset, ask for 1001.
    reset = 1'b0; en = 1'b1; sign = 1'b0; pwmIn = 1'b1;
    dead_then("v1", 4'b0000, 4'b1001);
    step("v1_hold", 4'b1001, 1'b0);

    // V2: pwmIn falls -> hiA off at once, loA after the dead interval.
    pwmIn = 1'b0;
    dead_then("v2", 4'b0001, 4'b0101);

    // Back to 1001 (loA off immediately, hiA after dead time).
    pwmIn = 1'b1;
    dead_then("v3_pre", 4'b0001, 4'b1001);

    // V3: polarity flip 1001 -> 0110 passes through all-off.
    sign = 1'b1;
    dead_then("v3", 4'b0000, 4'b0110);

    // V4: heading to 0101 from 0110, retarget to 1001 two cycles in.
    pwmIn = 1'b0;
    step("v4_a", 4'b0100, 1'b1);
    step("v4_b", 4'b0100, 1'b1);
    pwmIn = 1'b1; sign = 1'b0;
    dead_then("v4", 4'b0000, 4'b1001);

    // Go to 0110 for V5.
    sign = 1'b1;
    dead_then("v5_pre", 4'b0000, 4'b0110);

    // V5: fault pulse, clear-with-fault ignored, clear alone works.
    faultIn = 1'b1;
    tick();
    check("v5_f_out", {28'd0, hiA, loA, hiB, loB}, 32'd0);
    check("v5_f_flag", {31'd0, faulted}, 32'd1);
    check("v5_f_dead", {31'd0, deadActive}, 32'd0);
    clearFault = 1'b1;
    tick();
    check("v5_clr_ign", {31'd0, faulted}, 32'd1);
    faultIn = 1'b0; clearFault = 1'b0;
    tick();
    check("v5_hold_flag", {31'd0, faulted}, 32'd1);
    check("v5_hold_out", {28'd0, hiA, loA, hiB, loB}, 32'd0);
    clearFault = 1'b1;
    tick();
    check("v5_clr", {31'd0, faulted}, 32'd0);
    check("v5_clr_out", {28'd0, hiA, loA, hiB, loB}, 32'd0);
    clearFault = 1'b0;
    dead_then("v5", 4'b0000, 4'b0110);

    // Fault arriving mid-dead aborts the interval.
    sign = 1'b0;
    step("fd_a", 4'b0000, 1'b1);
    faultIn = 1'b1;
    step("fd_b", 4'b0000, 1'b0);
    check("fd_flag", {31'd0, faulted}, 32'd1);
    faultIn = 1'b0; clearFault = 1'b1;
    tick();
    clearFault = 1'b0;
    dead_then("fd", 4'b0000, 4'b1001);

    // V6: reach 0101, then drop en -> immediate off, no dead interval.
    pwmIn = 1'b0;
    dead_then("v6_pre", 4'b0001, 4'b0101);
    en = 1'b0;
    step("v6_en", 4'b0000, 1'b0);
    en = 1'b1;
    dead_then("v6_re", 4'b0000, 4'b0101);
    pwmIn = 1'b1;
    step("v6_d1", 4'b0001, 1'b1);
    step("v6_d2", 4'b0001, 1'b1);
    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    check("v6_rst_out", {28'd0, hiA, loA, hiB, loB}, 32'd0);
    check("v6_rst_dead", {31'd0, deadActive}, 32'd0);
    tick();
    reset = 1'b0;
    dead_then("v6_post", 4'b0000, 4'b1001);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
